pbpix_rr_arbiter: RTL and testbench

Round-robin arbiter that merges N zero-flagged pixel streams into one pbpix output stream with a registered output stage. It sits between multiple pixel producers (e.g. per-channel fetch units) and a single shared consumer such as a PE-array feeder. It grants bursts of up to BURST beats per requester, then rotates priority, and tags every output beat with its source index.

---
 rtl/pbpix_rr_arbiter.sv | 166 ++++++++++++++++
 tb/tb_pbpix_rr_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pbpix_rr_arbiter.sv
// Round-robin burst arbiter merging N zero-flagged pixel streams into one registered pbpix stream.
// Optional PBPIX_ARB_ZERO_DROP_EN: zero beats are swallowed instead of forwarded.
module pbpix_rr_arbiter #(
   parameter int unsigned N     = 4,
   parameter int unsigned DW    = 16,
   parameter int unsigned BURST = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rstn,
   input  logic [N-1:0]         in_rdy,
   output logic [N-1:0]         in_ack,
   input  logic [N-1:0]         in_zero,
   input  logic [N*DW-1:0]      in_data,
   output logic                 out_rdy,
   input  logic                 out_ack,
   output logic                 out_zero,
   output logic [DW-1:0]        out_data,
   output logic [$clog2(N)-1:0] out_src
);

   localparam int unsigned SW = $clog2(N);
   localparam int unsigned CW = 8;

   typedef enum logic {S_IDLE, S_LOCK} state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] owner_q, owner_d;
   logic [SW-1:0] ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          out_rdy_q, out_rdy_d;
   logic          out_zero_q, out_zero_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic [SW-1:0] out_src_q, out_src_d;

   logic          slot_free;
   logic          rel;
   logic          pick_vld;
   logic          want;
   logic          drop;
   logic          take;
   logic          load;
   logic          zero_ld;
   logic [SW-1:0] base;
   logic [SW-1:0] pick_idx;
   logic [SW-1:0] sel;
   logic [DW-1:0] sel_data;

   function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] a, input int unsigned b);
      int unsigned s;
      s = 32'(a) + b;
      if (s >= N) s = s - N;
      return SW'(s);
   endfunction

   // Arbitration, burst tracking and output-register next state
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      out_rdy_d  = out_rdy_q;
      out_zero_d = out_zero_q;
      out_data_d = out_data_q;
      out_src_d  = out_src_q;
      in_ack     = '0;
      rel        = 1'b0;
      base       = ptr_q;
      pick_vld   = 1'b0;
      pick_idx   = '0;
      want       = 1'b0;
      sel        = owner_q;
      sel_data   = '0;
      drop       = 1'b0;
      zero_ld    = 1'b0;
      take       = 1'b0;
      load       = 1'b0;

      slot_free = !out_rdy_q || out_ack;

      // Release rotates priority so the old owner is scanned last in the same-cycle re-pick
      if (state_q == S_LOCK && !(in_rdy[owner_q] && cnt_q < CW'(BURST))) begin
         rel  = 1'b1;
         base = wrap_add(owner_q, 1);
      end

      for (int k = int'(N) - 1; k >= 0; k--) begin
         if (in_rdy[wrap_add(base, 32'(k))]) begin
            pick_vld = 1'b1;
            pick_idx = wrap_add(base, 32'(k));
         end
      end

      if (state_q == S_LOCK && !rel) begin
         want = 1'b1;
         sel  = owner_q;
      end else if (pick_vld) begin
         want = 1'b1;
         sel  = pick_idx;
      end

      for (int i = 0; i < int'(N); i++) begin
         if (sel == SW'(i)) sel_data = in_data[i*DW +: DW];
      end

`ifdef PBPIX_ARB_ZERO_DROP_EN
      drop    = in_zero[sel];
      zero_ld = 1'b0;
`else
      drop    = 1'b0;
      zero_ld = in_zero[sel];
`endif

      take = want && in_rdy[sel] && (slot_free || drop);
      load = take && !drop;

      if (take && i_rstn) in_ack[sel] = 1'b1;

      if (rel) ptr_d = wrap_add(owner_q, 1);

      if (state_q == S_LOCK && !rel) begin
         if (load) cnt_d = CW'(cnt_q + CW'(1));
      end else if (take) begin
         state_d = S_LOCK;
         owner_d = sel;
         cnt_d   = drop ? '0 : CW'(1);
      end else begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end

      out_rdy_d = load || (out_rdy_q && !out_ack);
      if (load) begin
         out_zero_d = zero_ld;
         out_data_d = sel_data;
         out_src_d  = sel;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q    <= S_IDLE;
         owner_q    <= '0;
         ptr_q      <= '0;
         cnt_q      <= '0;
         out_rdy_q  <= 1'b0;
         out_zero_q <= 1'b0;
         out_data_q <= '0;
         out_src_q  <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         out_rdy_q  <= out_rdy_d;
         out_zero_q <= out_zero_d;
         out_data_q <= out_data_d;
         out_src_q  <= out_src_d;
      end
   end

   assign out_rdy  = out_rdy_q;
   assign out_zero = out_zero_q;
   assign out_data = out_data_q;
   assign out_src  = out_src_q;

endmodule

// File: tb/tb_pbpix_rr_arbiter.sv
// Directed self-checking bench for pbpix_rr_arbiter (N=4, DW=16, BURST=4).
module tb_pbpix_rr_arbiter;

   localparam int unsigned N     = 4;
   localparam int unsigned DW    = 16;
   localparam int unsigned BURST = 4;

   logic              i_clk;
   logic              i_rstn;
   logic [N-1:0]      in_rdy;
   logic [N-1:0]      in_ack;
   logic [N-1:0]      in_zero;
   logic [N*DW-1:0]   in_data;
   logic              out_rdy;
   logic              out_ack;
   logic              out_zero;
   logic [DW-1:0]     out_data;
   logic [1:0]        out_src;

   int total;
   int bad;

   logic [DW-1:0] qd [N][64];
   logic          qz [N][64];
   int            qh [N];
   int            qn [N];
   logic [N-1:0]  last_ack;

   pbpix_rr_arbiter #(.N(N), .DW(DW), .BURST(BURST)) dut (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .in_rdy  (in_rdy),
      .in_ack  (in_ack),
      .in_zero (in_zero),
      .in_data (in_data),
      .out_rdy (out_rdy),
      .out_ack (out_ack),
      .out_zero(out_zero),
      .out_data(out_data),
      .out_src (out_src)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_q();
      for (int i = 0; i < int'(N); i++) begin
         qh[i] = 0;
         qn[i] = 0;
      end
   endtask

   task automatic push(input int r, input logic [DW-1:0] d, input logic z);
      qd[r][qn[r]] = d;
      qz[r][qn[r]] = z;
      qn[r]++;
   endtask

   // Producers present the head of their queue until it is accepted
   task automatic drive();
      for (int i = 0; i < int'(N); i++) begin
         if (qh[i] < qn[i]) begin
            in_rdy[i]            = 1'b1;
            in_data[i*DW +: DW]  = qd[i][qh[i]];
            in_zero[i]           = qz[i][qh[i]];
         end else begin
            in_rdy[i]            = 1'b0;
            in_data[i*DW +: DW]  = '0;
            in_zero[i]           = 1'b0;
         end
      end
   endtask

   // One clock: sample acks mid-cycle, then pop accepted beats just after the edge
   task automatic tick();
      @(negedge i_clk);
      last_ack = in_ack;
      @(posedge i_clk);
      #1;
      for (int i = 0; i < int'(N); i++) begin
         if (last_ack[i]) qh[i]++;
      end
      drive();
   endtask

   task automatic do_reset();
      i_rstn  = 1'b0;
      out_ack = 1'b0;
      clear_q();
      drive();
      repeat (2) @(posedge i_clk);
      #1;
      i_rstn = 1'b1;
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      last_ack = '0;
      in_rdy   = '0;
      in_zero  = '0;
      in_data  = '0;
      out_ack  = 1'b0;
      i_rstn   = 1'b0;
      clear_q();

      // Reset state, with a requester already presenting a beat
      push(1, 16'h0abc, 1'b0);
      drive();
      #1;
      chk("rst_out_rdy", 32'(out_rdy), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_src", 32'(out_src), 0);
      chk("rst_out_zero", 32'(out_zero), 0);
      chk("rst_in_ack", 32'(in_ack), 0);

      // Sole requester 2, six beats, back-to-back across its own rotation
      do_reset();
      out_ack = 1'b1;
      for (int b = 0; b < 6; b++) push(2, 16'h0200 + 16'(b), 1'b0);
      drive();
      for (int b = 0; b < 6; b++) begin
         tick();
         chk("t1_ack", 32'(last_ack), 32'h4);
         chk("t1_rdy", 32'(out_rdy), 1);
         chk("t1_src", 32'(out_src), 2);
         chk("t1_data", 32'(out_data), 32'h0200 + 32'(b));
      end
      tick();
      chk("t1_drain", 32'(out_rdy), 0);

      // All four ready: bursts of four, rotating 0,1,2,3,0
      do_reset();
      out_ack = 1'b1;
      for (int r = 0; r < 4; r++)
         for (int b = 0; b < 8; b++) push(r, 16'(r * 256 + b), 1'b0);
      drive();
      for (int b = 0; b < 20; b++) begin
         tick();
         chk("t2_src", 32'(out_src), 32'((b / 4) % 4));
         chk("t2_data", 32'(out_data), 32'(((b / 4) % 4) * 256 + (b / 16) * 4 + (b % 4)));
         chk("t2_rdy", 32'(out_rdy), 1);
      end

      // Back-pressure: one beat buffered, no acks while stalled, order preserved
      do_reset();
      out_ack = 1'b0;
      for (int r = 0; r < 4; r++)
         for (int b = 0; b < 4; b++) push(r, 16'(r * 256 + b), 1'b0);
      drive();
      tick();
      chk("t3_first_ack", 32'(last_ack), 32'h1);
      for (int s = 0; s < 5; s++) begin
         tick();
         chk("t3_stall_ack", 32'(last_ack), 0);
         chk("t3_stall_rdy", 32'(out_rdy), 1);
         chk("t3_stall_data", 32'(out_data), 32'h0000);
      end
      out_ack = 1'b1;
      tick();
      chk("t3_res0", 32'(out_data), 32'h0001);
      tick();
      chk("t3_res1", 32'(out_data), 32'h0002);
      tick();
      chk("t3_res2", 32'(out_data), 32'h0003);
      tick();
      chk("t3_res3", 32'(out_data), 32'h0100);
      chk("t3_res3_src", 32'(out_src), 1);
      tick();
      chk("t3_res4", 32'(out_data), 32'h0101);

      // Owner 1 drops after two beats; requester 3 granted in the same cycle
      do_reset();
      out_ack = 1'b1;
      push(1, 16'h0100, 1'b0);
      push(1, 16'h0101, 1'b0);
      for (int b = 0; b < 4; b++) push(3, 16'h0300 + 16'(b), 1'b0);
      drive();
      tick();
      chk("t4_b0_src", 32'(out_src), 1);
      tick();
      chk("t4_b1_src", 32'(out_src), 1);
      chk("t4_b1_data", 32'(out_data), 32'h0101);
      tick();
      chk("t4_b2_rdy", 32'(out_rdy), 1);
      chk("t4_b2_src", 32'(out_src), 3);
      chk("t4_b2_data", 32'(out_data), 32'h0300);
      chk("t4_ptr", 32'(dut.ptr_q), 2);

      // Zero-flagged beat in the middle of a stream
      do_reset();
      out_ack = 1'b1;
      push(0, 16'd5, 1'b0);
      push(0, 16'd0, 1'b1);
      push(0, 16'd7, 1'b0);
      drive();
      tick();
      chk("t5_b0_data", 32'(out_data), 5);
      chk("t5_b0_zero", 32'(out_zero), 0);
      tick();
      chk("t5_b1_ack", 32'(last_ack), 32'h1);
`ifdef PBPIX_ARB_ZERO_DROP_EN
      chk("t5_b1_rdy", 32'(out_rdy), 0);
      chk("t5_b1_zero", 32'(out_zero), 0);
`else
      chk("t5_b1_rdy", 32'(out_rdy), 1);
      chk("t5_b1_data", 32'(out_data), 0);
      chk("t5_b1_zero", 32'(out_zero), 1);
`endif
      tick();
      chk("t5_b2_rdy", 32'(out_rdy), 1);
      chk("t5_b2_data", 32'(out_data), 7);
      chk("t5_b2_zero", 32'(out_zero), 0);

      // Async reset with a held beat and ptr moved to 2
      do_reset();
      out_ack = 1'b1;
      push(1, 16'h0100, 1'b0);
      for (int b = 0; b < 8; b++) push(2, 16'h0200 + 16'(b), 1'b0);
      drive();
      tick();
      chk("t6_pre_src1", 32'(out_src), 1);
      tick();
      chk("t6_pre_src2", 32'(out_src), 2);
      out_ack = 1'b0;
      tick();
      chk("t6_held_rdy", 32'(out_rdy), 1);
      chk("t6_held_data", 32'(out_data), 32'h0200);
      i_rstn = 1'b0;
      #1;
      chk("t6_rst_rdy", 32'(out_rdy), 0);
      chk("t6_rst_data", 32'(out_data), 0);
      chk("t6_rst_src", 32'(out_src), 0);
      chk("t6_rst_ack", 32'(in_ack), 0);
      push(0, 16'h0000, 1'b0);
      drive();
      @(posedge i_clk);
      #1;
      i_rstn  = 1'b1;
      out_ack = 1'b1;
      tick();
      chk("t6_post_ack", 32'(last_ack), 32'h1);
      chk("t6_post_src", 32'(out_src), 0);
      chk("t6_post_rdy", 32'(out_rdy), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
